// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register IDs,
// ALU controls and the M-stage register layout.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_BUB = 3'd0;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] R_NONE = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } m_reg_t;

    localparam m_reg_t M_BUBBLE = '{stat: S_BUB, icode: I_NOP, cnd: 1'b0,
                                    val_e: 64'd0, val_a: 64'd0,
                                    dst_e: R_NONE, dst_m: R_NONE};

    function automatic logic is_exception(input logic [2:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

endpackage

// File: rtl/alu_64.sv
// 64-bit Y86 ALU: add, subtract (A - B), and, xor with signed-overflow flag.
module alu_64
    import y86_pkg::*;
(
    input  logic [1:0]  Control,
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic [63:0] Sum,
    output logic        Overflow
);

    // operation select and two's-complement overflow detection
    always_comb begin
        Sum      = 64'd0;
        Overflow = 1'b0;
        case (Control)
            ALU_ADD: begin
                Sum      = A + B;
                Overflow = (A[63] == B[63]) && (Sum[63] != A[63]);
            end
            ALU_SUB: begin
                Sum      = A - B;
                Overflow = (A[63] != B[63]) && (Sum[63] != A[63]);
            end
            ALU_AND: Sum = A & B;
            ALU_XOR: Sum = A ^ B;
            default: begin
                Sum      = 64'd0;
                Overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cond_eval.sv
// Evaluates the jump / conditional-move condition from ifun and the CC flags.
module cond_eval (
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    // decode of the seven Y86 condition kinds; anything else is never taken
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = (sf ^ of) | zf;
            4'd2:    cnd = sf ^ of;
            4'd3:    cnd = zf;
            4'd4:    cnd = ~zf;
            4'd5:    cnd = ~(sf ^ of);
            4'd6:    cnd = ~(sf ^ of) & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 pipeline execute stage: ALU operand selection, condition codes,
// condition evaluation and the M pipeline register.
module execute_stage
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [63:0] E_valC,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    input  logic        M_stall,
    input  logic        M_bubble,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic [2:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic        cc_zf,
    output logic        cc_sf,
    output logic        cc_of
);

    logic [63:0] alu_a_s;
    logic [63:0] alu_b_s;
    logic [1:0]  alu_ctrl_s;
    logic        alu_ovf_s;
    logic        set_cc_s;
    logic        e_cnd_s;
    logic [2:0]  cc_r;
    m_reg_t      m_r;

    // operand and function selection by instruction class
    always_comb begin
        alu_a_s    = 64'd0;
        alu_b_s    = 64'd0;
        alu_ctrl_s = (E_icode == I_OPQ) ? E_ifun[1:0] : ALU_ADD;
        case (E_icode)
            I_RRMOVQ, I_OPQ:             alu_a_s = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a_s = E_valC;
            I_CALL, I_PUSHQ:             alu_a_s = 64'hFFFF_FFFF_FFFF_FFF8;
            I_RET, I_POPQ:               alu_a_s = 64'd8;
            default:                     alu_a_s = 64'd0;
        endcase
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ:
                     alu_b_s = E_valB;
            default: alu_b_s = 64'd0;
        endcase
    end

    // B-port gets aluA so subq computes valB - valA
    alu_64 u_alu (
        .Control  (alu_ctrl_s),
        .A        (alu_b_s),
        .B        (alu_a_s),
        .Sum      (e_valE),
        .Overflow (alu_ovf_s)
    );

    cond_eval u_cond (
        .ifun (E_ifun),
        .zf   (cc_r[2]),
        .sf   (cc_r[1]),
        .of   (cc_r[0]),
        .cnd  (e_cnd_s)
    );

    assign set_cc_s = (E_icode == I_OPQ) && !is_exception(m_stat) && !is_exception(W_stat);

    // a not-taken conditional move must not write its destination
    always_comb begin
        if ((E_icode == I_RRMOVQ) && !e_cnd_s) begin
            e_dstE = R_NONE;
        end else begin
            e_dstE = E_dstE;
        end
    end

    // condition-code register {zf, sf, of}
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_r <= 3'b100;
        end else if (set_cc_s) begin
            cc_r <= {(e_valE == 64'd0), e_valE[63], alu_ovf_s};
        end else begin
            cc_r <= cc_r;
        end
    end

    // M pipeline register: reset, stall, bubble, load in priority order
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_r <= M_BUBBLE;
        end else if (M_stall) begin
            m_r <= m_r;
        end else if (M_bubble) begin
            m_r <= M_BUBBLE;
        end else begin
            m_r <= '{stat: E_stat, icode: E_icode, cnd: e_cnd_s, val_e: e_valE,
                     val_a: E_valA, dst_e: e_dstE, dst_m: E_dstM};
        end
    end

    assign {cc_zf, cc_sf, cc_of} = cc_r;
    assign M_stat  = m_r.stat;
    assign M_icode = m_r.icode;
    assign M_Cnd   = m_r.cnd;
    assign M_valE  = m_r.val_e;
    assign M_valA  = m_r.val_a;
    assign M_dstE  = m_r.dst_e;
    assign M_dstM  = m_r.dst_m;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valA, E_valB, E_valC;
    logic [3:0]  E_dstE, E_dstM;
    logic [2:0]  m_stat, W_stat;
    logic        M_stall, M_bubble;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;
    logic        cc_zf, cc_sf, cc_of;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] vc, input logic [3:0] de);
        E_stat  = 3'd1;
        E_icode = icode;
        E_ifun  = ifun;
        E_valA  = va;
        E_valB  = vb;
        E_valC  = vc;
        E_dstE  = de;
        E_dstM  = 4'hF;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
        m_stat = 3'd1; W_stat = 3'd1;
        set_e(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
        tick();
        check("rst_icode", {60'd0, M_icode}, 64'd1);
        check("rst_stat", {61'd0, M_stat}, 64'd0);
        check("rst_dstE", {60'd0, M_dstE}, 64'hF);
        check("rst_valE", M_valE, 64'd0);
        check("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        rst_n = 1'b1;

        // subq 5-5 then jle
        set_e(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3);
        check("subq_valE", e_valE, 64'd0);
        check("subq_dstE", {60'd0, e_dstE}, 64'd3);
        tick();
        check("subq_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        check("subq_MvalE", M_valE, 64'd0);
        check("subq_Micode", {60'd0, M_icode}, 64'd6);
        set_e(4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 4'hF);
        tick();
        check("jle_cnd", {63'd0, M_Cnd}, 64'd1);
        check("jle_cc_hold", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);

        // subq 3-10 gives negative; jg not taken, jl taken
        set_e(4'h6, 4'h1, 64'd10, 64'd3, 64'd0, 4'h3);
        check("neg_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFF9);
        tick();
        check("neg_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b010);
        set_e(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 4'hF);
        tick();
        check("jg_cnd", {63'd0, M_Cnd}, 64'd0);
        set_e(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF);
        tick();
        check("jl_cnd", {63'd0, M_Cnd}, 64'd1);

        // signed overflow on addq, then CC gating by younger-stage exceptions
        set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h3);
        check("ovf_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        check("ovf_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);
        m_stat = 3'd3;
        set_e(4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'h3);
        tick();
        check("mstat_gate_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);
        m_stat = 3'd1; W_stat = 3'd4;
        set_e(4'h6, 4'h3, 64'd1, 64'd1, 64'd0, 4'h3);
        check("xorq_valE", e_valE, 64'd0);
        tick();
        check("wstat_gate_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);
        W_stat = 3'd1;

        // cmovne / cmove with ZF=1, irmovq, pushq
        set_e(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3);
        tick();
        set_e(4'h2, 4'h4, 64'h55, 64'd0, 64'd0, 4'h3);
        check("cmovne_valE", e_valE, 64'h55);
        check("cmovne_dstE", {60'd0, e_dstE}, 64'hF);
        tick();
        check("cmovne_MdstE", {60'd0, M_dstE}, 64'hF);
        check("cmovne_Mcnd", {63'd0, M_Cnd}, 64'd0);
        set_e(4'h2, 4'h3, 64'h55, 64'd0, 64'd0, 4'h3);
        check("cmove_dstE", {60'd0, e_dstE}, 64'd3);
        set_e(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h5);
        check("irmovq_valE", e_valE, 64'h1234);
        set_e(4'hA, 4'h0, 64'hABC, 64'h100, 64'd0, 4'h4);
        check("pushq_valE", e_valE, 64'hF8);
        tick();
        check("pushq_Micode", {60'd0, M_icode}, 64'hA);
        check("pushq_MvalA", M_valA, 64'hABC);

        // stall holds M for three edges while CC keeps updating
        M_stall = 1'b1;
        set_e(4'h6, 4'h1, 64'd1, 64'd3, 64'd0, 4'h7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_icode", {60'd0, M_icode}, 64'hA);
            check("stall_valE", M_valE, 64'hF8);
            check("stall_dstE", {60'd0, M_dstE}, 64'd4);
        end
        check("stall_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b000);
        M_bubble = 1'b1;
        set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h3);
        tick();
        check("stallbub_icode", {60'd0, M_icode}, 64'hA);
        check("stallbub_valA", M_valA, 64'hABC);
        check("stallbub_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);
        M_stall = 1'b0;
        tick();
        check("bub_icode", {60'd0, M_icode}, 64'd1);
        check("bub_stat", {61'd0, M_stat}, 64'd0);
        check("bub_vals", M_valE | M_valA, 64'd0);
        check("bub_dst", {56'd0, M_dstE, M_dstM}, 64'hFF);
        check("bub_cnd", {63'd0, M_Cnd}, 64'd0);

        // reset overrides stall and set_cc in the same edge
        M_bubble = 1'b0;
        set_e(4'h6, 4'h1, 64'd10, 64'd3, 64'd0, 4'h3);
        tick();
        M_stall = 1'b1;
        rst_n = 1'b0;
        tick();
        check("midrst_icode", {60'd0, M_icode}, 64'd1);
        check("midrst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        rst_n = 1'b1;
        M_stall = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-003 E_stat  input  3  status of instruction in E (0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-004 E_icode, E_ifun  input  4 each  instruction code and function of instruction in E.
REQ-005 E_valA, E_valB, E_valC  input  64 each  operands from the E pipeline register.
REQ-006 E_dstE, E_dstM  input  4 each  destination register IDs; 4'hF = RNONE.
REQ-007 m_stat, W_stat  input  3 each  status of the younger stages, used only for CC gating.
REQ-008 M_stall, M_bubble  input  1 each  pipeline control for the M register.
REQ-009 e_valE  output  64  combinational ALU result, forwarded to decode.
REQ-010 e_dstE  output  4  combinational, condition-adjusted dstE, forwarded to decode.
REQ-011 M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM  output  3/4/1/64/64/4/4  registered M-stage fields.
REQ-012 cc_zf, cc_sf, cc_of  output  1 each  current condition-code register.

Function
REQ-013 The block SHALL instantiate alu_64 with Control=E_ifun[1:0] for OPq (icode 6) and Control=2'b00 otherwise.
REQ-014 The aluA operand SHALL be: valA for icode 2/6; valC for 3/4/5; -8 for 8/A; +8 for 9/B; 0 otherwise.
REQ-015 The aluB operand SHALL be: valB for icode 4/5/6/8/9/A/B; 0 for 2/3 and otherwise.
REQ-016 alu_64 port A SHALL receive aluB and port B SHALL receive aluA, so subq yields valB-valA.
REQ-017 e_valE SHALL equal the alu_64 Sum; arithmetic wraps modulo 2^64.
REQ-018 set_cc SHALL be high iff E_icode==6, m_stat not in {2,3,4}, and W_stat not in {2,3,4}.
REQ-019 When set_cc is high, the CC register SHALL load ZF=(e_valE==0), SF=e_valE[63], OF=alu Overflow at the clock edge; otherwise it holds.
REQ-020 e_Cnd SHALL use the CC register value before this cycle's update: ifun 0 ->1; 1 ->(SF^OF)|ZF; 2 ->SF^OF; 3 ->ZF; 4 ->~ZF; 5 ->~(SF^OF); 6 ->~(SF^OF)&~ZF; ifun>6 ->0.
REQ-021 e_dstE SHALL be 4'hF when E_icode==2 and e_Cnd==0; otherwise E_dstE.
REQ-022 M register priority SHALL be: reset, then M_stall (hold all fields), then M_bubble (load bubble), then load.
REQ-023 Load SHALL capture E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM.
REQ-024 The bubble value SHALL be stat=0, icode=1 (nop), Cnd=0, valE=0, valA=0, dstE=dstM=4'hF.
REQ-025 With M_stall and M_bubble both high, stall SHALL win and the CC register SHALL still follow REQ-019.
REQ-026 Latency: e_* outputs combinational (0 cycles); M_* outputs valid 1 cycle after E inputs.

Reset
REQ-027 While rst_n=0 at a rising edge, the M register SHALL load the bubble value (REQ-024) and the CC register SHALL load ZF=1, SF=0, OF=0.
REQ-028 Reset asserted mid-operation SHALL override stall, bubble and set_cc in the same edge.
REQ-029 Combinational outputs SHALL be unaffected by rst_n except through the CC register.

Structure
REQ-030 Icode, stat, and RNONE constants plus ALU control encodings SHALL live in shared package y86_pkg.
REQ-031 alu_64 SHALL be reused unmodified; condition evaluation (REQ-020) SHALL be the single new sub-module cond_eval.
REQ-032 All state SHALL be the CC register (3 bits) and the M register; no other storage.

Verification
REQ-033 Reset: rst_n=0 one edge -> M_icode=1, M_stat=0, M_dstE=F, cc_zf=1, cc_sf=0, cc_of=0.
REQ-034 subq: E_icode=6, ifun=1, valA=5, valB=5 -> e_valE=0; next edge cc_zf=1, M_valE=0; then jle (7,1) -> e_Cnd=1.
REQ-035 Overflow: addq valA=valB=0x7FFF_FFFF_FFFF_FFFF -> e_valE=0xFFFF_FFFF_FFFF_FFFE, next cc_of=1, cc_sf=1; CC unchanged when m_stat=3 at the same edge.
REQ-036 cmovne with cc_zf=1: E_icode=2, ifun=4, E_dstE=3 -> e_dstE=F, M_dstE=F next edge; pushq valB=0x100 -> e_valE=0xF8.
REQ-037 Control: M_stall=1 holds all M_* for 3 edges; M_stall=M_bubble=1 holds; M_bubble alone -> bubble value.
